// File: rtl/cache_ctrl_pkg.sv
// cache_ctrl_pkg: state encoding and defaults shared by the write-back cache controller.
package cache_ctrl_pkg;
    localparam int CNT_WIDTH_DEF = 16;
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_COMPARE   = 3'd1;
    localparam logic [2:0] ST_WRITEBACK = 3'd2;
    localparam logic [2:0] ST_ALLOCATE  = 3'd3;
    localparam logic [2:0] ST_FILL      = 3'd4;
    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        COMPARE   = ST_COMPARE,
        WRITEBACK = ST_WRITEBACK,
        ALLOCATE  = ST_ALLOCATE,
        FILL      = ST_FILL
    } state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] r_count;
    always_ff @(posedge clk)
        if (rst) r_count <= '0;
        else if (inc && !(&r_count)) r_count <= r_count + WIDTH'(1);
    assign count = r_count;
endmodule

// File: rtl/cache_controller_wb.sv
// cache_controller_wb: control FSM for the 4-way write-back/write-allocate cache datapath,
// with saturating hit and miss counters.
module cache_controller_wb
    import cache_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 c_rd,
    input  logic                 c_wr,
    output logic                 c_ready,
    output logic                 m_rd,
    output logic                 m_wr,
    input  logic                 m_ready,
    input  logic                 Hit,
    input  logic                 valid,
    input  logic                 dirty,
    output logic                 sel_all,
    output logic                 rd,
    output logic                 wr,
    output logic                 update,
    output logic                 d_on_cpu,
    output logic                 d_on_mem,
    output logic                 adr_on_mem,
    output logic                 drt_adr_on_mem,
    output logic                 dirty_wr,
    output logic                 en_replacement,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);
    state_t r_state, w_next;
    logic   r_is_write, r_missed;
    logic   w_hit_inc, w_miss_inc;

    // r_missed keeps the post-fill COMPARE from counting as a hit or a second miss
    always_ff @(posedge clk)
        if (rst) begin
            r_state    <= IDLE;
            r_is_write <= 1'b0;
            r_missed   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && (c_rd || c_wr)) begin
                r_is_write <= c_wr;
                r_missed   <= 1'b0;
            end else if (r_state == COMPARE && !Hit) r_missed <= 1'b1;
        end

    always_comb begin
        w_next         = r_state;
        c_ready        = 1'b0;
        m_rd           = 1'b0;
        m_wr           = 1'b0;
        sel_all        = 1'b0;
        rd             = 1'b0;
        wr             = 1'b0;
        update         = 1'b0;
        d_on_cpu       = 1'b0;
        d_on_mem       = 1'b0;
        adr_on_mem     = 1'b0;
        drt_adr_on_mem = 1'b0;
        dirty_wr       = 1'b0;
        en_replacement = 1'b0;
        case (r_state)
            IDLE: w_next = (c_rd || c_wr) ? COMPARE : IDLE;
            COMPARE: begin
                rd = 1'b1;
                if (Hit) begin
                    c_ready        = 1'b1;
                    update         = 1'b1;
                    en_replacement = 1'b1;
                    wr             = r_is_write;
                    dirty_wr       = r_is_write;
                    d_on_cpu       = !r_is_write;
                    w_next         = IDLE;
                end else w_next = (valid && dirty) ? WRITEBACK : ALLOCATE;
            end
            WRITEBACK: begin
                rd             = 1'b1;
                d_on_mem       = 1'b1;
                drt_adr_on_mem = 1'b1;
                m_wr           = 1'b1;
                w_next         = m_ready ? ALLOCATE : WRITEBACK;
            end
            ALLOCATE: begin
                adr_on_mem = 1'b1;
                m_rd       = 1'b1;
                w_next     = m_ready ? FILL : ALLOCATE;
            end
            FILL: begin
                sel_all        = 1'b1;
                wr             = 1'b1;
                en_replacement = 1'b1;
                w_next         = COMPARE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_hit_inc  = (r_state == COMPARE) && Hit && !r_missed;
    assign w_miss_inc = (r_state == COMPARE) && !Hit && !r_missed;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_hit_inc),
        .count (hit_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_miss_inc),
        .count (miss_count)
    );
endmodule

// File: tb/tb_cache_controller_wb.sv
// tb_cache_controller_wb: directed request scenarios; expected control words come from a
// per-request cycle schedule and the counters from plain saturating integers.
module tb_cache_controller_wb;
    localparam int W = 4;
    localparam int CR = 12, MR = 11, MW = 10, SA = 9, RD = 8, WR = 7, UP = 6;
    localparam int DC = 5, DM = 4, AM = 3, DA = 2, DW = 1, ER = 0;
    localparam logic [12:0] V_IDLE = 13'd0;
    localparam logic [12:0] V_RHIT = 13'((1 << CR) | (1 << RD) | (1 << UP) | (1 << DC) | (1 << ER));
    localparam logic [12:0] V_WHIT = 13'((1 << CR) | (1 << RD) | (1 << WR) | (1 << DW) | (1 << UP) | (1 << ER));
    localparam logic [12:0] V_MISS = 13'(1 << RD);
    localparam logic [12:0] V_WB   = 13'((1 << RD) | (1 << DM) | (1 << DA) | (1 << MW));
    localparam logic [12:0] V_AL   = 13'((1 << AM) | (1 << MR));
    localparam logic [12:0] V_FILL = 13'((1 << SA) | (1 << WR) | (1 << ER));

    logic clk = 1'b0, rst = 1'b1;
    logic c_rd = 1'b0, c_wr = 1'b0, m_ready = 1'b0, Hit = 1'b0, valid = 1'b0, dirty = 1'b0;
    logic c_ready, m_rd, m_wr, sel_all, rd, wr, update, d_on_cpu, d_on_mem;
    logic adr_on_mem, drt_adr_on_mem, dirty_wr, en_replacement;
    logic [W-1:0] hit_count, miss_count;
    logic [12:0] w_act;
    logic [12:0] exp_vec = V_IDLE;
    bit exp_on = 1'b0;
    int n_tests = 0, n_fail = 0, m_hits = 0, m_misses = 0;

    always #5 clk = ~clk;

    cache_controller_wb #(.CNT_WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .c_rd           (c_rd),
        .c_wr           (c_wr),
        .c_ready        (c_ready),
        .m_rd           (m_rd),
        .m_wr           (m_wr),
        .m_ready        (m_ready),
        .Hit            (Hit),
        .valid          (valid),
        .dirty          (dirty),
        .sel_all        (sel_all),
        .rd             (rd),
        .wr             (wr),
        .update         (update),
        .d_on_cpu       (d_on_cpu),
        .d_on_mem       (d_on_mem),
        .adr_on_mem     (adr_on_mem),
        .drt_adr_on_mem (drt_adr_on_mem),
        .dirty_wr       (dirty_wr),
        .en_replacement (en_replacement),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    assign w_act = {c_ready, m_rd, m_wr, sel_all, rd, wr, update, d_on_cpu,
                    d_on_mem, adr_on_mem, drt_adr_on_mem, dirty_wr, en_replacement};

    function automatic int sat(input int n);
        return (n > (1 << W) - 1) ? (1 << W) - 1 : n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    always @(negedge clk)
        if (exp_on) begin
            chk("ctl", 32'(w_act), 32'(exp_vec));
            chk("hit_count", 32'(hit_count), 32'(sat(m_hits)));
            chk("miss_count", 32'(miss_count), 32'(sat(m_misses)));
            chk("m_excl", 32'(m_rd & m_wr), 32'd0);
        end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One request from an IDLE cycle: h = first compare hits, v/d = victim state,
    // tw/ta = extra memory wait cycles in write-back and allocate.
    task automatic req(input bit w, input bit r, input bit h, input bit v, input bit d,
                       input int tw, input int ta);
        c_wr = w; c_rd = r; Hit = h; valid = v; dirty = d; m_ready = 1'b1;
        exp_vec = V_IDLE;
        step();
        exp_vec = h ? (w ? V_WHIT : V_RHIT) : V_MISS;
        step();
        if (h) m_hits++;
        else begin
            m_misses++;
            if (v && d)
                for (int i = 0; i <= tw; i++) begin
                    m_ready = (i == tw); exp_vec = V_WB; step();
                end
            for (int i = 0; i <= ta; i++) begin
                m_ready = (i == ta); exp_vec = V_AL; step();
            end
            m_ready = 1'b1; Hit = 1'b1; exp_vec = V_FILL;
            step();
            m_ready = 1'b0; exp_vec = w ? V_WHIT : V_RHIT;
            step();
        end
        c_rd = 1'b0; c_wr = 1'b0; m_ready = 1'b0; exp_vec = V_IDLE;
    endtask

    initial begin
        step();
        exp_on = 1'b1;
        step();
        rst = 1'b0;
        req(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
        chk("lit_hit_after_rd_hit", 32'(hit_count), 32'd1);
        req(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0);
        req(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        chk("lit_hit_after_wr_hits", 32'(hit_count), 32'd3);
        req(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 2);
        chk("lit_miss_clean", 32'(miss_count), 32'd1);
        chk("lit_hit_unchanged", 32'(hit_count), 32'd3);
        req(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0);
        req(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
        req(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1);
        chk("lit_miss_total", 32'(miss_count), 32'd4);
        req(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        req(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        chk("lit_hit_b2b", 32'(hit_count), 32'd5);
        // reset while allocating with m_rd high
        c_rd = 1'b1; Hit = 1'b0; valid = 1'b0; dirty = 1'b0; exp_vec = V_IDLE;
        step();
        exp_vec = V_MISS;
        step();
        m_misses++;
        rst = 1'b1; exp_vec = V_AL;
        step();
        rst = 1'b0; c_rd = 1'b0; m_hits = 0; m_misses = 0; exp_vec = V_IDLE;
        step();
        chk("lit_rst_hit", 32'(hit_count), 32'd0);
        chk("lit_rst_miss", 32'(miss_count), 32'd0);
        for (int i = 0; i < 17; i++) req(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        chk("lit_hit_sat", 32'(hit_count), 32'd15);
        step();
        exp_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
